// File: rtl/branch_target_buffer_if.sv
// Fetch/resolve bus between the pipeline and the branch target buffer.
// The master drives lookups and resolved-branch updates; the slave returns predictions.
interface branch_target_buffer_if #(
   parameter int HIST_W = 4
);
   logic [31:0]       fetch_pc;
   logic              pred_taken;
   logic [31:0]       pred_target;
   logic [HIST_W-1:0] pred_ghr;
   logic              upd_en;
   logic [31:0]       upd_pc;
   logic              upd_taken;
   logic [31:0]       upd_target;
   logic              upd_pred_taken;
   logic [HIST_W-1:0] upd_ghr;
   logic [31:0]       mispred_cnt;

   modport master (
      output fetch_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_ghr,
      input  pred_taken, pred_target, pred_ghr, mispred_cnt
   );

   modport slave (
      input  fetch_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_ghr,
      output pred_taken, pred_target, pred_ghr, mispred_cnt
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with saturating-counter direction prediction; combinational lookup, registered update.
// Optional gshare global history is enabled by defining BTB_GSHARE_EN.
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int HIST_W  = 4
) (
   input logic                    CLK,
   input logic                    nRST,
   branch_target_buffer_if.slave  bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;
   localparam int unsigned WT_INT = 1 << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(WT_INT);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(WT_INT - 1);

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q    [ENTRIES];
   logic [31:0]        mispredCnt_q;

   logic [IDX_W-1:0] fetchIdx;
   logic [TAG_W-1:0] fetchTag;
   logic [IDX_W-1:0] fetchPidx;
   logic [IDX_W-1:0] updIdx;
   logic [TAG_W-1:0] updTag;
   logic [IDX_W-1:0] updPidx;
   logic             fetchHit;
   logic             updHit;
   logic             predTaken;

   assign fetchIdx = bus.fetch_pc[IDX_W+1:2];
   assign fetchTag = bus.fetch_pc[31:IDX_W+2];
   assign updIdx   = bus.upd_pc[IDX_W+1:2];
   assign updTag   = bus.upd_pc[31:IDX_W+2];

`ifdef BTB_GSHARE_EN
   logic [HIST_W-1:0] ghr_q;
   logic [HIST_W-1:0] ghr_d;

   // History shifts in the resolved outcome; the shift form also covers HIST_W=1.
   assign ghr_d        = (ghr_q << 1) | HIST_W'(bus.upd_taken);
   assign fetchPidx    = fetchIdx ^ IDX_W'(ghr_q);
   assign updPidx      = updIdx ^ IDX_W'(bus.upd_ghr);
   assign bus.pred_ghr = ghr_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ghr_q <= '0;
      end else if (bus.upd_en) begin
         ghr_q <= ghr_d;
      end
   end
`else
   assign fetchPidx    = fetchIdx;
   assign updPidx      = updIdx;
   assign bus.pred_ghr = '0;
`endif

   assign fetchHit = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
   assign updHit   = valid_q[updIdx] && (tag_q[updIdx] == updTag);
   assign predTaken = fetchHit && ctr_q[fetchPidx][CTR_W-1];

   assign bus.pred_taken  = predTaken;
   assign bus.pred_target = predTaken ? target_q[fetchIdx] : 32'd0;
   assign bus.mispred_cnt = mispredCnt_q;

   // Lookups see only pre-update state; a write lands on the edge and is visible next cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid_q      <= '0;
         mispredCnt_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else if (bus.upd_en) begin
         if (bus.upd_taken != bus.upd_pred_taken) begin
            mispredCnt_q <= mispredCnt_q + 32'd1;
         end
         if (updHit) begin
            if (bus.upd_taken) begin
               target_q[updIdx] <= bus.upd_target;
               if (ctr_q[updPidx] != CTR_MAX) begin
                  ctr_q[updPidx] <= ctr_q[updPidx] + CTR_W'(1);
               end
            end else if (ctr_q[updPidx] != '0) begin
               ctr_q[updPidx] <= ctr_q[updPidx] - CTR_W'(1);
            end
         end else if (bus.upd_taken) begin
            valid_q[updIdx]  <= 1'b1;
            tag_q[updIdx]    <= updTag;
            target_q[updIdx] <= bus.upd_target;
            ctr_q[updPidx]   <= CTR_WT;
         end
      end
   end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with saturating-counter direction prediction for the pipelined datapath's fetch stage. It generalises the single `pred_taken` bit carried down the pipeline latches into a parametrised predictor with configurable depth and counter width, and an optional gshare history. Fetch reads it combinationally every cycle. The execute/memory stage writes resolved branch outcomes back into it.

## Interface
- `ENTRIES`, 16: number of BTB/PHT entries; power of two, ≥2; `IDX_W = $clog2(ENTRIES)`.
- `CTR_W`, 2: direction counter width, ≥1.
- `HIST_W`, 4: global history width; 1 ≤ `HIST_W` ≤ `IDX_W`; used only with `BTB_GSHARE_EN`.
- `CLK  in  1`: clock; all state updates on the rising edge.
- `nRST  in  1`: reset; asynchronous, active-low.
- `fetch_pc  in  32`: PC of the instruction being fetched (word aligned).
- `pred_taken  out  1`: predict taken.
- `pred_target  out  32`: predicted target; 0 when `pred_taken`=0.
- `pred_ghr  out  HIST_W`: history used for this lookup, carried down the pipeline; 0 without the macro.
- `upd_en  in  1`: one resolved branch this cycle.
- `upd_pc  in  32`: PC of the resolved branch.
- `upd_taken  in  1`: actual outcome.
- `upd_target  in  32`: actual target; valid when `upd_taken`=1.
- `upd_pred_taken  in  1`: prediction that was made for this branch.
- `upd_ghr  in  HIST_W`: `pred_ghr` captured when this branch was fetched.
- `mispred_cnt  out  32`: count of resolved mispredictions.

## Operation
- Address split: `idx = pc[IDX_W+1:2]`, `tag = pc[31:IDX_W+2]`. Bits [1:0] are ignored.
- BTB entry state: `valid`, `tag`, and a 32-bit `target`.
- PHT state: `ENTRIES` counters of `CTR_W` bits each, indexed by `pidx`.
  - Without the macro, `pidx = idx`.
- Lookup (combinational):
  - `hit = valid[idx] && tag[idx]==tag(fetch_pc)`.
  - `pred_taken = hit && ctr[pidx][CTR_W-1]`.
  - `pred_target = pred_taken ? target[idx] : 0`.
- Update (registered, on `upd_en`):
  - **Hit on `upd_pc`:**
    - `upd_taken`=1: counter increments and saturates at `2^CTR_W-1`; `target` is overwritten with `upd_target`.
    - `upd_taken`=0: counter decrements and saturates at 0.
  - **Miss and `upd_taken`=1:** the entry is allocated or replaced.
    - `valid`=1; tag and target are written.
    - Counter is set to weakly taken, `2^(CTR_W-1)`.
  - **Miss and `upd_taken`=0:** no change to the BTB or PHT.
- Misprediction count: `mispred_cnt` increments when `upd_en && (upd_taken != upd_pred_taken)`. It wraps modulo 2^32.
- Simultaneous lookup and update of the same index in the same cycle: the lookup returns the pre-update state. There is no bypass.

## Timing
- Lookup latency is 0 cycles, combinational from `fetch_pc`.
- An update is visible to a lookup in the cycle after the `upd_en` edge.
- Reset values:
  - All `valid`=0.
  - All counters = weakly not-taken, `2^(CTR_W-1)-1`.
  - All tags and targets = 0.
  - GHR = 0; `mispred_cnt` = 0.
- Reset-driven outputs: `pred_taken`=0 and `pred_target`=0 for any `fetch_pc`. `pred_ghr`=0.
- Reset asserted mid-stream discards any in-flight update in that cycle.
- At most one update per cycle. No stall input: `upd_en` must be asserted once per resolved branch by the producer.

## Configuration
- `BTB_GSHARE_EN` defined:
  - A `HIST_W` global history register (GHR) is added; it is updated non-speculatively at resolve.
  - Lookup: `pidx = idx ^ {{(IDX_W-HIST_W){1'b0}}, ghr}`; `pred_ghr = ghr`.
  - Update: `pidx = idx(upd_pc) ^ upd_ghr`.
  - On `upd_en`, `ghr <= {ghr[HIST_W-2:0], upd_taken}`, or `ghr <= upd_taken` when `HIST_W`=1.
  - BTB tag and target remain indexed by `idx`.
- `BTB_GSHARE_EN` undefined:
  - There is no GHR; `pidx = idx`.
  - `pred_ghr` is tied to 0 and `upd_ghr` is ignored.

## Test plan
- Reset with `nRST`=0, then lookup `fetch_pc`=0x40 → `pred_taken`=0, `pred_target`=0, `mispred_cnt`=0.
- Update `upd_pc`=0x40, `upd_taken`=1, `upd_target`=0x100, `upd_pred_taken`=0; next cycle lookup 0x40 → `pred_taken`=1, `pred_target`=0x100, `mispred_cnt`=1.
- Aliasing (ENTRIES=16): after the allocation above, lookup 0x80 (same idx, different tag) → `pred_taken`=0.
  - Then update 0x80 taken, target 0x200.
  - Lookup 0x40 → 0; lookup 0x80 → taken with target 0x200.
- Counter saturation (CTR_W=2): apply 3 not-taken updates to an allocated entry.
  - Counter reaches 0 and `pred_taken`=0.
  - One taken update → counter 1, still not taken.
  - Second taken update → counter 2, predicts taken.
- Same-cycle hazard: with 0x40 entry at counter 2 (predicting taken), apply a not-taken update while looking up 0x40.
  - That cycle: `pred_taken`=1.
  - Next cycle: `pred_taken`=0.
- With `BTB_GSHARE_EN`, HIST_W=4: four taken updates at PC 0x0 (the first allocates it) drive GHR to 4'b1111 and `pred_ghr`=0xF.
  - The next lookup of 0x0 reads counter index 0xF, which is still at its reset value 1, so `pred_taken`=0 even though the BTB hits.
